// File: rtl/dp_axi_loader_pkg.sv
// ============================================================
// dp_axi_loader_pkg: shared mode encodings and FSM states
// Rev 1.0
// ============================================================
`default_nettype none

package dp_axi_loader_pkg;

    localparam logic [1:0] M_CTXT = 2'b01;
    localparam logic [1:0] M_PTXT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic mode_valid(input logic [1:0] mode);
        return (mode == M_CTXT) || (mode == M_PTXT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dp_load_cnt.sv
// ============================================================
// dp_load_cnt: address / poly / half counter with final-beat flag
// Rev 1.0
// ============================================================
`default_nettype none

module dp_load_cnt
    import dp_axi_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_POLY   = 3,
    parameter int POLY_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_inc,
    input  logic [1:0]            i_mode,
    input  logic                  i_sel,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [POLY_W-1:0]     o_poly,
    output logic                  o_half,
    output logic                  o_final
);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [POLY_W-1:0]     r_poly;
    logic                  r_half;
    logic                  r_ctxt;
    logic                  w_addr_wrap;
    logic                  w_poly_wrap;

    assign w_addr_wrap = &r_addr;
    assign w_poly_wrap = (r_poly == POLY_W'(NUM_POLY - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_poly <= '0;
            r_half <= 1'b0;
            r_ctxt <= 1'b0;
        end else if (i_clr) begin
            r_addr <= '0;
            r_poly <= '0;
            r_ctxt <= (i_mode == M_CTXT);
            // ctxt always starts in half 0; ptxt stays on the selected half
            r_half <= (i_mode == M_CTXT) ? 1'b0 : i_sel;
        end else if (i_inc) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
            if (w_addr_wrap) begin
                if (w_poly_wrap) begin
                    r_poly <= '0;
                    r_half <= 1'b1;
                end else begin
                    r_poly <= r_poly + POLY_W'(1);
                end
            end
        end
    end

    assign o_addr  = r_addr;
    assign o_poly  = r_poly;
    assign o_half  = r_half;
    assign o_final = w_addr_wrap && w_poly_wrap && (!r_ctxt || r_half);

endmodule

`default_nettype wire

// File: rtl/dp_axi_loader.sv
// ============================================================
// dp_axi_loader: streams coefficient beats into banked poly RAMs
// Rev 1.0
// ============================================================
`default_nettype none

module dp_axi_loader
    import dp_axi_loader_pkg::*;
#(
    parameter int COE_WIDTH     = 39,
    parameter int ADDR_WIDTH    = 9,
    parameter int NUM_POLY      = 3,
    parameter int NUM_BASE_BANK = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [1:0]                           i_mode,
    input  logic                                 i_buf_sel,
    input  logic                                 i_start,
    input  logic                                 i_clear,
    input  logic                                 i_valid,
    output logic                                 o_ready,
    input  logic [COE_WIDTH*NUM_BASE_BANK-1:0]   i_data,
    input  logic                                 i_last,
    output logic [NUM_BASE_BANK*NUM_POLY*2-1:0]  o_axi_we,
    output logic [ADDR_WIDTH*NUM_BASE_BANK-1:0]  o_axi_wraddr,
    output logic [COE_WIDTH*NUM_BASE_BANK-1:0]   o_axi_data,
    output logic                                 o_axi_done,
    output logic                                 o_err
);

    localparam int c_we_w   = NUM_BASE_BANK * NUM_POLY * 2;
    localparam int c_poly_w = (NUM_POLY > 1) ? $clog2(NUM_POLY) : 1;
    localparam int c_g_w    = $clog2(2 * NUM_POLY);

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic                            w_accept;
    logic                            w_cnt_clr;
    logic                            w_err_set;
    logic                            w_err_clr;
    logic [ADDR_WIDTH-1:0]           w_addr;
    logic [c_poly_w-1:0]             w_poly;
    logic                            w_half;
    logic                            w_final;
    logic [c_g_w-1:0]                w_gidx;
    logic [c_we_w-1:0]               w_we;
    logic [c_we_w-1:0]               r_we;
    logic [ADDR_WIDTH*NUM_BASE_BANK-1:0] r_wraddr;
    logic [COE_WIDTH*NUM_BASE_BANK-1:0]  r_data;
    logic                            r_done;
    logic                            r_err;

    dp_load_cnt #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_POLY   (NUM_POLY),
        .POLY_W     (c_poly_w)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_accept),
        .i_mode  (i_mode),
        .i_sel   (i_buf_sel),
        .o_addr  (w_addr),
        .o_poly  (w_poly),
        .o_half  (w_half),
        .o_final (w_final)
    );

    // Global poly index selects one bank group of write enables
    assign w_gidx = (w_half ? c_g_w'(NUM_POLY) : c_g_w'(0)) + c_g_w'(w_poly);

    for (genvar g = 0; g < 2 * NUM_POLY; g++) begin : g_we
        assign w_we[g*NUM_BASE_BANK +: NUM_BASE_BANK] = {NUM_BASE_BANK{w_gidx == c_g_w'(g)}};
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_cnt_clr   = 1'b0;
        w_err_set   = 1'b0;
        w_err_clr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (mode_valid(i_mode)) begin
                        w_cnt_clr   = 1'b1;
                        w_err_clr   = 1'b1;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                w_accept = i_valid;
                if (i_valid) begin
                    // Early or missing i_last is flagged; either way the beat is written
                    w_err_set = (i_last != w_final);
                    if (w_final || i_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (i_clear) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_we     <= '0;
            r_wraddr <= '0;
            r_data   <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= w_accept ? w_we : '0;
            if (w_accept) begin
                r_wraddr <= {NUM_BASE_BANK{w_addr}};
                r_data   <= i_data;
            end
            r_done <= (r_state == S_DONE) && !i_clear;
            if (w_err_clr) begin
                r_err <= 1'b0;
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_ready      = (r_state == S_LOAD);
    assign o_axi_we     = r_we;
    assign o_axi_wraddr = r_wraddr;
    assign o_axi_data   = r_data;
    assign o_axi_done   = r_done;
    assign o_err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dp_axi_loader.sv
// ============================================================
// tb_dp_axi_loader: randomized loads checked against a beat-level model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_dp_axi_loader;

    localparam int CW    = 39;
    localparam int AW    = 9;
    localparam int NP    = 3;
    localparam int NB    = 8;
    localparam int DEPTH = 1 << AW;
    localparam int WE_W  = NB * NP * 2;
    localparam int DW    = CW * NB;

    logic            clk;
    logic            rst_n;
    logic [1:0]      i_mode;
    logic            i_buf_sel;
    logic            i_start;
    logic            i_clear;
    logic            i_valid;
    logic            o_ready;
    logic [DW-1:0]   i_data;
    logic            i_last;
    logic [WE_W-1:0] o_axi_we;
    logic [AW*NB-1:0] o_axi_wraddr;
    logic [DW-1:0]   o_axi_data;
    logic            o_axi_done;
    logic            o_err;

    dp_axi_loader #(
        .COE_WIDTH     (CW),
        .ADDR_WIDTH    (AW),
        .NUM_POLY      (NP),
        .NUM_BASE_BANK (NB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_mode       (i_mode),
        .i_buf_sel    (i_buf_sel),
        .i_start      (i_start),
        .i_clear      (i_clear),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data       (i_data),
        .i_last       (i_last),
        .o_axi_we     (o_axi_we),
        .o_axi_wraddr (o_axi_wraddr),
        .o_axi_data   (o_axi_data),
        .o_axi_done   (o_axi_done),
        .o_err        (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Beat-level reference: 0 idle, 1 loading, 2 done
    int              m_state = 0;
    int              m_n = 0;
    int              m_total = 0;
    int              m_base = 0;
    logic            m_err = 1'b0;
    logic [WE_W-1:0] e_we = '0;
    logic [AW-1:0]   e_addr = '0;
    logic [DW-1:0]   e_data = '0;
    logic            e_done = 1'b0;
    logic            e_ready = 1'b0;

    int              dut_writes = 0;
    int              spot_beat = -1;
    logic [WE_W-1:0] spot_we = '0;
    int              spot_addr = 0;

    typedef struct {
        logic [1:0]      mode;
        logic            sel;
        int              gap;        // 0 gapless, 1 toggle 1,0, 2 random
        int              last_at;    // beat carrying i_last, -1 none
        int              exp_writes;
        logic            exp_err;
        int              sbeat;
        logic [WE_W-1:0] swe;
        int              saddr;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        logic was_done;
        logic fin;
        int g;
        if (!rst_n) begin
            m_state = 0; m_n = 0; m_err = 1'b0;
            e_we = '0; e_addr = '0; e_data = '0; e_done = 1'b0;
        end else begin
            was_done = (m_state == 2);
            e_we = '0;
            case (m_state)
                0: if (i_start) begin
                    if (i_mode == 2'b01 || i_mode == 2'b10) begin
                        m_total = (i_mode == 2'b01) ? 2 * NP * DEPTH : NP * DEPTH;
                        m_base  = (i_mode == 2'b01) ? 0 : (i_buf_sel ? NP : 0);
                        m_n = 0; m_err = 1'b0; m_state = 1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                1: if (i_valid) begin
                    g = m_base + m_n / DEPTH;
                    e_we[g*NB +: NB] = '1;
                    e_addr = AW'(m_n % DEPTH);
                    e_data = i_data;
                    fin = (m_n == m_total - 1);
                    if (i_last != fin) m_err = 1'b1;
                    if (fin || i_last) m_state = 2;
                    m_n++;
                end
                2: if (i_clear) m_state = 0;
                default: m_state = 0;
            endcase
            e_done = was_done && !i_clear;
        end
        e_ready = (m_state == 1);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("ready", 320'(o_ready), 320'(e_ready));
        chk("we", 320'(o_axi_we), 320'(e_we));
        chk("wraddr", 320'(o_axi_wraddr), 320'({NB{e_addr}}));
        chk("data", 320'(o_axi_data), 320'(e_data));
        chk("done", 320'(o_axi_done), 320'(e_done));
        chk("err", 320'(o_err), 320'(m_err));
        if (o_axi_we != '0) begin
            if (dut_writes == spot_beat) begin
                chk("spot_we", 320'(o_axi_we), 320'(spot_we));
                chk("spot_addr", 320'(o_axi_wraddr[AW-1:0]), 320'(spot_addr));
            end
            dut_writes++;
        end
    endtask

    task automatic rand_data();
        logic [319:0] tmp;
        for (int k = 0; k < 10; k++) tmp[k*32 +: 32] = $urandom;
        i_data = tmp[DW-1:0];
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        dut_writes = 0;
        spot_beat = v.sbeat; spot_we = v.swe; spot_addr = v.saddr;
        i_mode = v.mode; i_buf_sel = v.sel; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        cyc = 0;
        while (m_state == 1 && cyc < 8000) begin
            case (v.gap)
                0: i_valid = 1'b1;
                1: i_valid = (cyc % 2 == 0);
                default: i_valid = 1'($urandom);
            endcase
            rand_data();
            i_last = i_valid && ((v.last_at >= 0) ? (m_n == v.last_at) : 1'b0);
            i_start = ($urandom % 32 == 0);
            i_mode = 2'($urandom);
            i_clear = ($urandom % 32 == 0);
            tick();
            cyc++;
        end
        if (cyc >= 8000) chk("load_timeout", 320'(cyc), 320'(0));
        i_valid = 1'b0; i_last = 1'b0; i_start = 1'b0; i_clear = 1'b0;
        tick();
        chk("writes", 320'(dut_writes), 320'(v.exp_writes));
        chk("end_err", 320'(o_err), 320'(v.exp_err));
        chk("end_done", 320'(o_axi_done), 320'(1));
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        chk("clear_done", 320'(o_axi_done), 320'(0));
        tick();
        spot_beat = -1;
    endtask

    initial begin
        vecs[0] = '{2'b10, 1'b0, 0, 1535, 1536, 1'b0, 0,    48'h0000_0000_00FF, 0};
        vecs[1] = '{2'b10, 1'b0, 0, 1535, 1536, 1'b0, 512,  48'h0000_0000_FF00, 0};
        vecs[2] = '{2'b10, 1'b0, 0, 1535, 1536, 1'b0, 1535, 48'h0000_00FF_0000, 511};
        vecs[3] = '{2'b01, 1'b0, 0, 3071, 3072, 1'b0, 1536, 48'h0000_FF00_0000, 0};
        vecs[4] = '{2'b10, 1'b1, 1, 1535, 1536, 1'b0, 0,    48'h0000_FF00_0000, 0};
        vecs[5] = '{2'b10, 1'b0, 2, 100,  101,  1'b1, 100,  48'h0000_0000_00FF, 100};
        vecs[6] = '{2'b01, 1'b1, 2, -1,   3072, 1'b1, 3071, 48'hFF00_0000_0000, 511};

        rst_n = 1'b0; i_mode = 2'b00; i_buf_sel = 1'b0; i_start = 1'b0;
        i_clear = 1'b0; i_valid = 1'b0; i_data = '0; i_last = 1'b0;
        tick();
        tick();
        chk("rst_we", 320'(o_axi_we), 320'(0));
        chk("rst_done", 320'(o_axi_done), 320'(0));
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Valid start clears the sticky error left by the previous load
        i_mode = 2'b10; i_buf_sel = 1'b0; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("start_clears_err", 320'(o_err), 320'(0));
        while (m_n < 700) begin
            i_valid = 1'b1; rand_data();
            tick();
        end
        rst_n = 1'b0;
        tick();
        chk("midrst_we", 320'(o_axi_we), 320'(0));
        chk("midrst_addr", 320'(o_axi_wraddr), 320'(0));
        chk("midrst_data", 320'(o_axi_data), 320'(0));
        chk("midrst_ready", 320'(o_ready), 320'(0));
        chk("midrst_err", 320'(o_err), 320'(0));
        rst_n = 1'b1;
        tick();
        chk("postrst_idle", 320'(o_ready), 320'(0));
        i_valid = 1'b0;

        // Illegal modes flag an error and never open the beat port
        i_mode = 2'b11; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("bad_mode_err", 320'(o_err), 320'(1));
        chk("bad_mode_ready", 320'(o_ready), 320'(0));
        i_valid = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("bad_mode_nowrite", 320'(o_axi_we), 320'(0));
        i_mode = 2'b00; i_start = 1'b1;
        tick();
        i_start = 1'b0; i_valid = 1'b0;
        chk("mode00_err", 320'(o_err), 320'(1));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
